// File: rtl/v1_peak_detector_if.sv
// Event output channel of the peak detector: one captured pulse per valid/ready handshake.
interface v1_peak_detector_if #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int TS_WIDTH         = 32,
  parameter int WBITS            = 7
);
  logic                               peak_valid;
  logic                               peak_ready;
  logic signed [SIZE_FILTER_DATA:0]   peak_amp;
  logic        [TS_WIDTH-1:0]         peak_time;
  logic        [WBITS-1:0]            pulse_width;
  logic                               peak_sat;

  modport master (
    output peak_valid, peak_amp, peak_time, pulse_width, peak_sat,
    input  peak_ready
  );

  modport slave (
    input  peak_valid, peak_amp, peak_time, pulse_width, peak_sat,
    output peak_ready
  );
endinterface

// File: rtl/v1_peak_detector.sv
// Threshold pulse detector behind the v1 shaping filter: captures peak amplitude,
// peak timestamp and width per pulse and offers it through a 1-deep output register.
module v1_peak_detector #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int THRESHOLD        = 200,
  parameter int MAX_WIDTH        = 64,
  parameter int HOLDOFF          = 8,
  parameter int TS_WIDTH         = 32,
  parameter int WBITS            = 7
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic signed [SIZE_FILTER_DATA:0] filter_data,
  v1_peak_detector_if.master               peak,
  output logic        [7:0]                lost_count
);

  localparam int DW  = SIZE_FILTER_DATA + 1;
  localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic signed [DW-1:0] TH   = DW'(THRESHOLD);
  localparam logic [WBITS-1:0]     MAXW = WBITS'(MAX_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_EMIT,
    ST_HOLDOFF,
    ST_WAIT_LOW
  } state_t;

  state_t                 state_q;
  logic [TS_WIDTH-1:0]    ts_q;
  logic signed [DW-1:0]   x_q;
  logic [TS_WIDTH-1:0]    xts_q;
  logic signed [DW-1:0]   max_q;
  logic [TS_WIDTH-1:0]    tmax_q;
  logic [WBITS-1:0]       width_q;
  logic                   sat_q;
  logic [HCW-1:0]         hold_q;

  logic                   valid_q;
  logic signed [DW-1:0]   amp_q;
  logic [TS_WIDTH-1:0]    time_q;
  logic [WBITS-1:0]       owidth_q;
  logic                   osat_q;
  logic [7:0]             lost_q;

  logic                   x_hi;
  logic [WBITS-1:0]       width_inc;

  always_comb begin
    x_hi      = (x_q > TH);
    width_inc = width_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ts_q     <= '0;
      x_q      <= '0;
      xts_q    <= '0;
      max_q    <= '0;
      tmax_q   <= '0;
      width_q  <= '0;
      sat_q    <= 1'b0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      amp_q    <= '0;
      time_q   <= '0;
      owidth_q <= '0;
      osat_q   <= 1'b0;
      lost_q   <= '0;
    end else begin
      ts_q  <= ts_q + 1'b1;
      x_q   <= filter_data;
      xts_q <= ts_q;

      // Accepted events retire here; a load in ST_EMIT below takes precedence.
      if (valid_q && peak.peak_ready) valid_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (x_hi) begin
            state_q <= ST_ACTIVE;
            max_q   <= x_q;
            tmax_q  <= xts_q;
            width_q <= WBITS'(1);
          end
        end
        ST_ACTIVE: begin
          if (x_hi) begin
            width_q <= width_inc;
            if (x_q > max_q) begin
              max_q  <= x_q;
              tmax_q <= xts_q;
            end
            if (width_inc == MAXW) begin
              sat_q   <= 1'b1;
              state_q <= ST_EMIT;
            end
          end else begin
            sat_q   <= 1'b0;
            state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (!valid_q || peak.peak_ready) begin
            valid_q  <= 1'b1;
            amp_q    <= max_q;
            time_q   <= tmax_q;
            owidth_q <= width_q;
            osat_q   <= sat_q;
          end else if (lost_q != 8'hFF) begin
            lost_q <= lost_q + 1'b1;
          end
          hold_q  <= HCW'(HOLDOFF - 1);
          state_q <= ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          if (hold_q == '0) state_q <= ST_WAIT_LOW;
          else              hold_q  <= hold_q - 1'b1;
        end
        ST_WAIT_LOW: begin
          if (!x_hi) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign peak.peak_valid  = valid_q;
  assign peak.peak_amp    = amp_q;
  assign peak.peak_time   = time_q;
  assign peak.pulse_width = owidth_q;
  assign peak.peak_sat    = osat_q;
  assign lost_count       = lost_q;

endmodule
